// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory behind valid/ready request and response channels, fixed LATENCY.
// Define DM_BYTE_EN to add the req_be port and byte-lane store enables.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DM_BYTE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [2:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wmask;
    logic [31:0] mem [DEPTH_WORDS];
    logic        bad;
    logic [AW-1:0] idx;
    assign bad = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(DEPTH_WORDS);
    assign idx = addr_q[AW+1:2];
    assign req_ready = state == IDLE;
`ifdef DM_BYTE_EN
    logic [3:0] be_q;
    always_ff @(posedge clk)
        if (!reset) be_q <= '0;
        else if (state == IDLE && req_valid) be_q <= req_be;
    assign wmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`else
    assign wmask = '1;
`endif
    // The access commits on the edge that leaves WAIT, so a reset in WAIT drops it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cnt     <= 3'(LATENCY - 1);
                    state   <= WAIT;
                end
                WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
                else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= bad;
                    resp_rdata <= (bad || we_q) ? 32'd0 : mem[idx];
                    if (we_q && !bad) mem[idx] <= (mem[idx] & ~wmask) | (wdata_q & wmask);
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and random accesses against a word-map reference model.
module tb_dm_responder;
    localparam int DEPTH = 3072;
    localparam int LAT = 2;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = 4'hF;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [int];
    logic [31:0] got;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef DM_BYTE_EN
        .req_be(req_be),
`endif
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive garbage on the request side; a correct responder ignores it outside IDLE.
    task automatic junk();
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // One complete transaction with exact latency, hold-stability and handshake checks.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, output logic [31:0] rdata);
        logic [31:0] exp_d;
        logic [31:0] cur;
        logic        exp_e;
        logic [3:0]  eff_be;
        int          w;
`ifdef DM_BYTE_EN
        eff_be = be;
`else
        eff_be = 4'hF;
`endif
        exp_e = addr[1:0] != 2'b00 || addr[31:2] >= 30'(DEPTH);
        w = int'(addr[31:2]);
        cur = (!exp_e && model.exists(w)) ? model[w] : 32'd0;
        exp_d = (we || exp_e) ? 32'd0 : cur;
        if (we && !exp_e) begin
            for (int b = 0; b < 4; b++) if (eff_be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
            model[w] = cur;
        end
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        junk();
        for (int c = 1; c <= LAT; c++) begin
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("early_valid", {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
            junk();
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_rdata", resp_rdata, exp_d);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_e});
        rdata = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            junk();
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_d);
            chk("hold_err", {31'd0, resp_err}, {31'd0, exp_e});
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: rand_addr = 32'h2FFC;
            1: rand_addr = 32'h3000 + {$urandom_range(0, 63), 2'b00};
            2: rand_addr = {$urandom_range(0, 15), 2'b00} | 32'($urandom_range(1, 3));
            3: rand_addr = $urandom | 32'h8000_0000;
            default: rand_addr = {$urandom_range(0, 15), 2'b00};
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        access(1'b0, 32'h0000, 32'd0, 4'hF, 0, got);
        access(1'b1, 32'h0010, 32'hDEADBEEF, 4'hF, 0, got);
        access(1'b0, 32'h0010, 32'd0, 4'hF, 0, got);
        chk("load_deadbeef", got, 32'hDEADBEEF);

        access(1'b1, 32'h2FFC, 32'hCAFE0001, 4'hF, 0, got);
        access(1'b0, 32'h0013, 32'd0, 4'hF, 0, got);
        access(1'b1, 32'h3000, 32'h55AA55AA, 4'hF, 0, got);
        access(1'b0, 32'h2FFC, 32'd0, 4'hF, 0, got);
        chk("edge_word", got, 32'hCAFE0001);
        access(1'b0, 32'h0010, 32'd0, 4'hF, 5, got);

        // Reset while a store is in WAIT: no response and memory cleared.
        access(1'b1, 32'h0020, 32'h12345678, 4'hF, 0, got);
        chk("ready_pre", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0020; req_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("wrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("wrst_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        model.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no_stray", {31'd0, resp_valid}, 32'd0);
        end
        access(1'b0, 32'h0020, 32'd0, 4'hF, 0, got);
        chk("abort_store", got, 32'd0);
        access(1'b0, 32'h0010, 32'd0, 4'hF, 0, got);
        chk("mem_cleared", got, 32'd0);

`ifdef DM_BYTE_EN
        access(1'b1, 32'h0040, 32'hFFFFFFFF, 4'hF, 0, got);
        access(1'b1, 32'h0040, 32'h000000AA, 4'b0001, 0, got);
        access(1'b0, 32'h0040, 32'd0, 4'hF, 0, got);
        chk("be_merge", got, 32'hFFFFFFAA);
        access(1'b1, 32'h0040, 32'h11111111, 4'b0000, 0, got);
        access(1'b0, 32'h0040, 32'd0, 4'hF, 0, got);
        chk("be_none", got, 32'hFFFFFFAA);
`else
        access(1'b1, 32'h0040, 32'hFFFFFFFF, 4'hF, 0, got);
        access(1'b1, 32'h0040, 32'h000000AA, 4'b0001, 0, got);
        access(1'b0, 32'h0040, 32'd0, 4'hF, 0, got);
        chk("full_store", got, 32'h000000AA);
`endif

        for (int n = 0; n < 60; n++)
            access(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3), got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072, number of 32-bit words stored (byte range 0x0000-0x2FFF).
REQ-002 Parameter LATENCY, default 2, legal 1..7, cycles from request acceptance to resp_valid assertion.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables, bit i covers wdata[8i+7:8i]; present only when DM_BYTE_EN is defined.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: req_valid=1 captures we/addr/wdata/be into internal registers and moves to WAIT with counter loaded to LATENCY-1.
REQ-017 WAIT: counter decrements each cycle; at counter 0 the next edge commits the access and enters RESP.
REQ-018 resp_valid SHALL first assert exactly LATENCY cycles after the acceptance edge.
REQ-019 Commit edge: loads sample mem[addr[31:2]] into resp_rdata; stores write mem[addr[31:2]].
REQ-020 RESP: resp_valid, resp_rdata, resp_err held stable until resp_ready=1; handshake edge returns to IDLE with resp_valid=0.
REQ-021 Back-to-back throughput: one access per LATENCY+2 cycles; no request accepted in the cycle of the response handshake.
REQ-022 resp_err=1 when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; memory SHALL not be modified; resp_rdata=0.
REQ-023 Store-then-load to the same address SHALL return the stored value (commit precedes any later acceptance).
REQ-024 Request inputs are ignored outside IDLE; changes after acceptance have no effect.

Reset
REQ-025 reset=0 at a rising edge: state to IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 after release.
REQ-026 reset SHALL clear every memory word to 0.
REQ-027 reset during WAIT aborts the access; an uncommitted store SHALL not be written; no response is produced.

Configuration
REQ-028 Macro DM_BYTE_EN: when defined, req_be exists and stores update only enabled bytes; req_be=4'b0000 store leaves memory unchanged and responds resp_err=0.
REQ-029 Without DM_BYTE_EN: req_be port is absent and every store writes all 32 bits.

Verification
REQ-030 Reset then load addr 0x0000, LATENCY=2 -> resp_valid exactly 2 cycles after acceptance, rdata 0x00000000, err 0.
REQ-031 Store 0xDEADBEEF to 0x0010, then load 0x0010 -> rdata 0xDEADBEEF, err 0, req_ready low during WAIT/RESP.
REQ-032 Load 0x0013 and store 0x3000 -> resp_err 1, rdata 0, subsequent load 0x2FFC unaffected.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable all 5 cycles, IDLE one edge after resp_ready=1.
REQ-034 Store 0x12345678 to 0x0020, assert reset in WAIT, then load 0x0020 -> rdata 0x00000000, no stray response.
REQ-035 DM_BYTE_EN: store 0xFFFFFFFF to 0x0040, store 0x000000AA with be=4'b0001 -> load returns 0xFFFFFFAA.
